// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if
// Bundles the pixel-source handshake and the row-beat bus of the 9x9 window
// feeder into one interface.
//
// Parameters:
//   DATA_W  signed pixel width
//
// Signals:
//   pixel_valid_in   source presents a pixel
//   pixel_in         signed pixel, raster order
//   pixel_ready_out  feeder accepts a pixel this cycle
//   conv_ready_in    consumer accepts a beat
//   data_valid_out   beat valid
//   data_out         9 pixels of one window row, [j] = column hcount+j
//   row_num_out      window row index 0..8 of this beat
//   hcount_out       window column
//   vcount_out       window row
//   frame_done_out   one-cycle pulse after the last beat of a frame
//
// Modports:
//   master  the feeder itself (drives the beat bus and pixel_ready_out)
//   slave   the surrounding environment (pixel source plus conv engine)

interface conv_window_feeder_if #(
   parameter int DATA_W = 21
);
   logic                      pixel_valid_in;
   logic signed [DATA_W-1:0]  pixel_in;
   logic                      pixel_ready_out;
   logic                      conv_ready_in;
   logic                      data_valid_out;
   logic [8:0][DATA_W-1:0]    data_out;
   logic [3:0]                row_num_out;
   logic [4:0]                hcount_out;
   logic [4:0]                vcount_out;
   logic                      frame_done_out;

   modport master (
      input  pixel_valid_in, pixel_in, conv_ready_in,
      output pixel_ready_out, data_valid_out, data_out,
             row_num_out, hcount_out, vcount_out, frame_done_out
   );

   modport slave (
      output pixel_valid_in, pixel_in, conv_ready_in,
      input  pixel_ready_out, data_valid_out, data_out,
             row_num_out, hcount_out, vcount_out, frame_done_out
   );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Producer side of the 9x9 convolution row interface. Buffers one
// IMG_W x IMG_H frame of signed pixels, then streams every 9x9 window as
// 9 row beats (row_num 0..8), each tagged with the window hcount/vcount.
// After the last beat of the frame a one-cycle frame_done_out pulse is
// issued and the feeder goes back to accepting pixels.
//
// Parameters:
//   IMG_W, IMG_H  frame size in pixels (<=32, counts are 5 bits)
//   K             window size, must be 9
//   DATA_W        signed pixel width
//
// Ports:
//   clk_in    system clock
//   rst_n_in  synchronous reset, active-low
//   bus       conv_window_feeder_if.master (pixel handshake + beat bus)
//
// Configuration macro:
//   ZERO_PAD_EN  when defined, windows are centred on every pixel and
//                out-of-frame taps read as 0; when undefined only fully
//                inside windows are produced and no padding logic exists.

module conv_window_feeder #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 9,
   parameter int DATA_W = 21
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   conv_window_feeder_if.master  bus
);

`ifdef ZERO_PAD_EN
   localparam logic [4:0] HMAX = 5'(IMG_W - 1);
   localparam logic [4:0] VMAX = 5'(IMG_H - 1);
   localparam int         OFS  = K / 2;
`else
   localparam logic [4:0] HMAX = 5'(IMG_W - K);
   localparam logic [4:0] VMAX = 5'(IMG_H - K);
`endif

   typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

   state_t                   state;
   logic [4:0]               fill_row;
   logic [4:0]               fill_col;
   logic signed [DATA_W-1:0] frame_buf [IMG_H][IMG_W];

   logic                     pixel_accept;
   logic [3:0]               nxt_row;
   logic [4:0]               nxt_h;
   logic [4:0]               nxt_v;
   logic                     last_beat;
   logic [8:0][DATA_W-1:0]   win_data;

   // Pixels are only taken while filling; anything offered during EMIT or
   // DONE is left for the source to hold.
   assign bus.pixel_ready_out = (state == FILL);
   assign pixel_accept        = bus.pixel_valid_in && (state == FILL);

   // Frame storage has no reset: a partial frame is simply overwritten
   // because the fill counters restart at (0,0).
   always_ff @(posedge clk_in) begin
      if (pixel_accept) begin
         frame_buf[fill_row][fill_col] <= bus.pixel_in;
      end
   end

   // Coordinates of the beat to load next. With no beat on the bus yet the
   // first beat of the frame (0,0,0) is selected; otherwise the current beat
   // is advanced: row first, then column, then window row.
   always_comb begin
      nxt_row   = '0;
      nxt_h     = '0;
      nxt_v     = '0;
      last_beat = 1'b0;
      if (bus.data_valid_out) begin
         nxt_h = bus.hcount_out;
         nxt_v = bus.vcount_out;
         if (bus.row_num_out != 4'd8) begin
            nxt_row = bus.row_num_out + 4'd1;
         end else if (bus.hcount_out != HMAX) begin
            nxt_h = bus.hcount_out + 5'd1;
         end else begin
            nxt_h = '0;
            nxt_v = bus.vcount_out + 5'd1;
         end
         last_beat = (bus.row_num_out == 4'd8) && (bus.hcount_out == HMAX) &&
                     (bus.vcount_out == VMAX);
      end
   end

`ifdef ZERO_PAD_EN
   int src_r;
   int src_c;

   // Centred windows: taps are offset by half a window and any tap that
   // falls outside the frame contributes zero.
   always_comb begin
      win_data = '0;
      src_r    = 0;
      src_c    = 0;
      for (int j = 0; j < 9; j++) begin
         src_r = int'(nxt_v) + int'(nxt_row) - OFS;
         src_c = int'(nxt_h) + j - OFS;
         if (src_r >= 0 && src_r < IMG_H && src_c >= 0 && src_c < IMG_W) begin
            win_data[j] = frame_buf[src_r[4:0]][src_c[4:0]];
         end
      end
   end
`else
   // Valid-only windows: every tap is inside the frame by construction.
   always_comb begin
      win_data = '0;
      for (int j = 0; j < 9; j++) begin
         win_data[j] = frame_buf[nxt_v + 5'(nxt_row)][nxt_h + 5'(j)];
      end
   end
`endif

   // Main FSM. The output registers double as the window position counters,
   // so a stalled beat (valid && !ready) keeps every output frozen.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state              <= FILL;
         fill_row           <= '0;
         fill_col           <= '0;
         bus.data_valid_out <= 1'b0;
         bus.data_out       <= '0;
         bus.row_num_out    <= '0;
         bus.hcount_out     <= '0;
         bus.vcount_out     <= '0;
         bus.frame_done_out <= 1'b0;
      end else begin
         bus.frame_done_out <= 1'b0;
         case (state)
            FILL: begin
               if (pixel_accept) begin
                  if (fill_col == 5'(IMG_W - 1)) begin
                     fill_col <= '0;
                     if (fill_row == 5'(IMG_H - 1)) begin
                        fill_row <= '0;
                        state    <= EMIT;
                     end else begin
                        fill_row <= fill_row + 5'd1;
                     end
                  end else begin
                     fill_col <= fill_col + 5'd1;
                  end
               end
            end
            EMIT: begin
               if (!bus.data_valid_out || bus.conv_ready_in) begin
                  if (last_beat) begin
                     bus.data_valid_out <= 1'b0;
                     bus.frame_done_out <= 1'b1;
                     state              <= DONE;
                  end else begin
                     bus.data_valid_out <= 1'b1;
                     bus.data_out       <= win_data;
                     bus.row_num_out    <= nxt_row;
                     bus.hcount_out     <= nxt_h;
                     bus.vcount_out     <= nxt_v;
                  end
               end
            end
            DONE: begin
               state <= FILL;
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder
// Scoreboard bench for conv_window_feeder. Each frame is generated (ramp or
// random pixels), every window beat it should produce is computed from the
// frame image and queued, and a negedge monitor pops and compares whenever a
// beat transfers. Also exercises backpressure, pixel_valid held during EMIT,
// and a reset in the middle of a frame. Honours ZERO_PAD_EN.

module tb_conv_window_feeder;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int DATA_W = 21;
`ifdef ZERO_PAD_EN
   localparam int NH  = IMG_W;
   localparam int NV  = IMG_H;
   localparam int PAD = 4;
`else
   localparam int NH  = IMG_W - 8;
   localparam int NV  = IMG_H - 8;
   localparam int PAD = 0;
`endif
   localparam int TOTAL = NH * NV * 9;

   typedef struct {
      logic [3:0]             row;
      logic [4:0]             h;
      logic [4:0]             v;
      logic [8:0][DATA_W-1:0] data;
   } beat_t;

   logic clk_in = 1'b0;
   logic rst_n_in;

   always #5 clk_in = ~clk_in;

   conv_window_feeder_if #(.DATA_W(DATA_W)) bus ();

   conv_window_feeder #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .K      (9),
      .DATA_W (DATA_W)
   ) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   beat_t             expQ[$];
   logic [DATA_W-1:0] img [IMG_H][IMG_W];
   int                errors = 0;
   int                checks = 0;
   int                beats  = 0;
   int                frames = 0;

   logic              heldValid = 1'b0;
   logic [255:0]      heldOut;
   logic              prevDone = 1'b0;

   task automatic checkOutput(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every window of the frame, in emission order, straight from the image:
   // tap (rn, j) of window (h, v) is pixel (v+rn-PAD, h+j-PAD), zero outside.
   function automatic void pushFrame();
      beat_t b;
      int    r;
      int    c;
      for (int v = 0; v < NV; v++) begin
         for (int h = 0; h < NH; h++) begin
            for (int rn = 0; rn < 9; rn++) begin
               b.row  = 4'(rn);
               b.h    = 5'(h);
               b.v    = 5'(v);
               b.data = '0;
               for (int j = 0; j < 9; j++) begin
                  r = v + rn - PAD;
                  c = h + j - PAD;
                  if (r >= 0 && r < IMG_H && c >= 0 && c < IMG_W) begin
                     b.data[j] = img[r][c];
                  end
               end
               expQ.push_back(b);
            end
         end
      end
   endfunction

   // Builds one frame, queues its expected beats and feeds it in raster
   // order. Called and returns at posedge+1.
   task automatic applyStimulus(input bit ramp, input bit holdValid);
      beats = 0;
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            img[r][c] = ramp ? DATA_W'(r * IMG_W + c) : DATA_W'($urandom);
         end
      end
      pushFrame();
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            if (!ramp && $urandom_range(0, 3) == 0) begin
               bus.pixel_valid_in = 1'b0;
               @(posedge clk_in); #1;
            end
            bus.pixel_valid_in = 1'b1;
            bus.pixel_in       = img[r][c];
            if (r == 0 && c == 0) begin
               checkOutput("pixel_ready_fill", 256'(bus.pixel_ready_out), 256'(1));
            end
            @(posedge clk_in); #1;
         end
      end
      if (holdValid) begin
         bus.pixel_in = 21'h15555;
      end else begin
         bus.pixel_valid_in = 1'b0;
      end
   endtask

   // Drives conv_ready_in until frame_done_out. mode 0: always ready,
   // mode 1: random ready, mode 2: 5-cycle stall at the first row_num=3 beat.
   task automatic waitFrame(input int mode);
      bit done      = 1'b0;
      bit stalled   = 1'b0;
      int stallLeft = 0;
      checkOutput("pixel_ready_emit", 256'(bus.pixel_ready_out), 256'(0));
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         if (bus.frame_done_out) begin
            done = 1'b1;
         end else begin
            if (mode == 1) begin
               bus.conv_ready_in = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
               if (!stalled && bus.data_valid_out && bus.row_num_out == 4'd3) begin
                  stalled   = 1'b1;
                  stallLeft = 5;
               end
               bus.conv_ready_in = (stallLeft == 0);
               if (stallLeft > 0) stallLeft--;
            end else begin
               bus.conv_ready_in = 1'b1;
            end
            @(posedge clk_in); #1;
         end
      end
      checkOutput("frame_done_seen", 256'(done), 256'(1));
      if (mode == 2) checkOutput("stall_applied", 256'(stalled), 256'(1));
      bus.pixel_valid_in = 1'b0;
      bus.conv_ready_in  = 1'b1;
      @(posedge clk_in); #1;
      checkOutput("frame_done_width", 256'(bus.frame_done_out), 256'(0));
      checkOutput("pixel_ready_after_done", 256'(bus.pixel_ready_out), 256'(1));
      checkOutput("beats_per_frame", 256'(beats), 256'(TOTAL));
   endtask

   // Monitor: frozen outputs under backpressure, beat scoreboard, frame_done.
   always @(negedge clk_in) begin
      beat_t e;
      if (rst_n_in) begin
         if (heldValid) begin
            checkOutput("stall_hold", {bus.data_valid_out, bus.row_num_out, bus.hcount_out,
                                       bus.vcount_out, bus.data_out}, heldOut);
         end
         heldValid = bus.data_valid_out && !bus.conv_ready_in;
         heldOut   = {bus.data_valid_out, bus.row_num_out, bus.hcount_out,
                      bus.vcount_out, bus.data_out};
         if (bus.data_valid_out && bus.conv_ready_in) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_beat", 256'(1), 256'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("beat", {bus.row_num_out, bus.hcount_out, bus.vcount_out, bus.data_out},
                           {e.row, e.h, e.v, e.data});
            end
            beats++;
         end
         if (bus.frame_done_out) begin
            frames++;
            checkOutput("queue_empty_at_done", 256'(expQ.size()), 256'(0));
            if (prevDone) checkOutput("frame_done_pulse", 256'(1), 256'(0));
         end
         prevDone = bus.frame_done_out;
      end else begin
         heldValid = 1'b0;
         prevDone  = 1'b0;
      end
   end

   initial begin
      int f0;
      bit hit;
      rst_n_in           = 1'b0;
      bus.pixel_valid_in = 1'b0;
      bus.pixel_in       = '0;
      bus.conv_ready_in  = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      checkOutput("reset_outputs", {bus.data_valid_out, bus.frame_done_out, bus.row_num_out,
                                    bus.hcount_out, bus.vcount_out, bus.data_out}, '0);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      checkOutput("pixel_ready_after_reset", 256'(bus.pixel_ready_out), 256'(1));

      // Ramp frame, pixel_valid_in held high through EMIT.
      applyStimulus(1'b1, 1'b1);
      waitFrame(0);
      // Random frame; its first window proves buf[0][0] came from the new frame.
      applyStimulus(1'b0, 1'b0);
      waitFrame(2);
      applyStimulus(1'b0, 1'b0);
      waitFrame(1);

      // Reset in the middle of EMIT at beat 1000.
      applyStimulus(1'b1, 1'b0);
      hit = 1'b0;
      for (int cyc = 0; cyc < 20000 && !hit; cyc++) begin
         if (beats >= 1000) hit = 1'b1;
         else begin
            @(posedge clk_in); #1;
         end
      end
      checkOutput("reached_beat_1000", 256'(hit), 256'(1));
      f0       = frames;
      rst_n_in = 1'b0;
      @(posedge clk_in); #1;
      checkOutput("midframe_reset_outputs", {bus.data_valid_out, bus.frame_done_out,
                                             bus.row_num_out, bus.hcount_out,
                                             bus.vcount_out, bus.data_out}, '0);
      expQ.delete();
      rst_n_in = 1'b1;
      repeat (20) @(posedge clk_in);
      #1;
      checkOutput("no_done_after_abort", 256'(frames), 256'(f0));
      checkOutput("pixel_ready_after_abort", 256'(bus.pixel_ready_out), 256'(1));

      // Fresh ramp frame after the aborted one.
      applyStimulus(1'b1, 1'b0);
      waitFrame(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
